timer_bus_client: RTL and testbench

// - Hardware bus initiator for the memory-mapped 64-bit machine timer; drives the timer's 32-bit slave port (addr/wdata/wr/rstrb/rdata).
// - Provides atomic 64-bit mtime/mtimecmp reads (hi-lo-hi with retry), glitch-free 64-bit mtimecmp writes, and a relative "arm" (mtimecmp = mtime + delta).
// - Sits between a command source (CPU-side accelerator, debug or scheduler logic) and the timer, so no irq glitches while mtimecmp is updated.

---
 rtl/timer_bus_client.sv | 208 ++++++++++++++++++++
 tb/tb_timer_bus_client.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_client.sv
// Bus initiator for the 64-bit machine timer: atomic hi-lo-hi reads, ordered mtimecmp writes, relative arm.
// Optional periodic self re-arm is enabled with `define TIMER_CLIENT_PERIODIC_EN.
module timer_bus_client #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          MAX_RETRY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wr,
    output logic        rstrb,
    input  logic [31:0] rdata
`ifdef TIMER_CLIENT_PERIODIC_EN
   ,input  logic        irq,
    input  logic        periodic_on,
    input  logic [31:0] period
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_WR_HIFF, S_WR_LO, S_WR_HI, S_RESP
    } state_t;

    localparam logic [1:0] OP_RD_CMP = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_ARM    = 2'b11;
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi1_q, hi1_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] wval_q, wval_d;
    logic [3:0]  retry_q, retry_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        start_int;
    logic [31:0] rd_base;

`ifdef TIMER_CLIENT_PERIODIC_EN
    logic        internal_q, internal_d;
    logic [63:0] cmp_sh_q, cmp_sh_d;
    assign start_int = (state_q == S_IDLE) && irq && periodic_on;
`else
    assign start_int = 1'b0;
`endif

    assign rd_base = BASE_ADDR + ((op_q == OP_RD_CMP) ? 32'h8 : 32'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            hi1_q      <= 32'd0;
            lo_q       <= 32'd0;
            wval_q     <= 64'd0;
            retry_q    <= 4'd0;
            rsp_data_q <= 64'd0;
            rsp_err_q  <= 1'b0;
`ifdef TIMER_CLIENT_PERIODIC_EN
            internal_q <= 1'b0;
            cmp_sh_q   <= 64'd0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi1_q      <= hi1_d;
            lo_q       <= lo_d;
            wval_q     <= wval_d;
            retry_q    <= retry_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef TIMER_CLIENT_PERIODIC_EN
            internal_q <= internal_d;
            cmp_sh_q   <= cmp_sh_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi1_d      = hi1_q;
        lo_d       = lo_q;
        wval_d     = wval_q;
        retry_d    = retry_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef TIMER_CLIENT_PERIODIC_EN
        internal_d = internal_q;
        cmp_sh_d   = cmp_sh_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_int) begin
`ifdef TIMER_CLIENT_PERIODIC_EN
                    wval_d     = cmp_sh_q + {32'd0, period};
                    internal_d = 1'b1;
`endif
                    state_d = S_WR_HIFF;
                end else if (req_valid) begin
`ifdef TIMER_CLIENT_PERIODIC_EN
                    internal_d = 1'b0;
`endif
                    op_d    = req_op;
                    wval_d  = req_data;
                    retry_d = 4'd0;
                    state_d = (req_op == OP_WRITE) ? S_WR_HIFF : S_RD_HI1;
                end
            end
            S_RD_HI1: begin
                hi1_d   = rdata;
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                lo_d    = rdata;
                state_d = S_RD_HI2;
            end
            S_RD_HI2: begin
                if (rdata == hi1_q) begin
                    if (op_q == OP_ARM) begin
                        // wval still holds the delta here; it becomes the absolute compare value
                        wval_d  = {hi1_q, lo_q} + wval_q;
                        state_d = S_WR_HIFF;
                    end else begin
                        rsp_data_d = {hi1_q, lo_q};
                        rsp_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end
                end else if (retry_q == RETRY_LAST) begin
                    rsp_data_d = {rdata, lo_q};
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_RD_HI1;
                end
            end
            S_WR_HIFF: state_d = S_WR_LO;
            S_WR_LO:   state_d = S_WR_HI;
            S_WR_HI: begin
                rsp_data_d = wval_q;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
`ifdef TIMER_CLIENT_PERIODIC_EN
                cmp_sh_d = wval_q;
                if (internal_q) begin
                    rsp_data_d = rsp_data_q;
                    rsp_err_d  = rsp_err_q;
                    state_d    = S_IDLE;
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr      = BASE_ADDR;
        wdata     = 32'd0;
        wr        = 4'h0;
        rstrb     = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            S_IDLE:   req_ready = !rst && !start_int;
            S_RD_HI1, S_RD_HI2: begin
                addr  = rd_base + 32'h4;
                rstrb = 1'b1;
            end
            S_RD_LO: begin
                addr  = rd_base;
                rstrb = 1'b1;
            end
            // cmp_hi is parked at all-ones first so no intermediate value can trip irq
            S_WR_HIFF: begin
                addr  = BASE_ADDR + 32'hC;
                wdata = 32'hFFFF_FFFF;
                wr    = 4'hF;
            end
            S_WR_LO: begin
                addr  = BASE_ADDR + 32'h8;
                wdata = wval_q[31:0];
                wr    = 4'hF;
            end
            S_WR_HI: begin
                addr  = BASE_ADDR + 32'hC;
                wdata = wval_q[63:32];
                wr    = 4'hF;
            end
            S_RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_timer_bus_client.sv
// Bench for timer_bus_client: behavioural timer slave plus an arithmetic model of the expected responses.
`timescale 1ns/1ps
module tb_timer_bus_client;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int MAXR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_op = 2'b00;
    logic [63:0] req_data = 64'd0;
    logic rsp_valid;
    logic [63:0] rsp_data;
    logic rsp_err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] wr;
    logic rstrb;
`ifdef TIMER_CLIENT_PERIODIC_EN
    logic irq_p = 1'b0;
    logic periodic_on = 1'b0;
    logic [31:0] period = 32'd0;
`endif

    timer_bus_client #(.BASE_ADDR(BASE), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .addr(addr), .wdata(wdata),
        .wr(wr), .rstrb(rstrb), .rdata(rdata)
`ifdef TIMER_CLIENT_PERIODIC_EN
       ,.irq(irq_p), .periodic_on(periodic_on), .period(period)
`endif
    );

    always #5 clk = ~clk;

    // Timer slave: mtime = mt_base + free-running cycle count
    logic [63:0] cyc = 64'd0;
    logic [63:0] mt_base = 64'd0;
    logic [63:0] cmp_m = '1;
    logic [31:0] h_base = 32'd0;
    logic [31:0] hreads = 32'd0;
    logic bad = 1'b0;
    wire [63:0] mtime = mt_base + cyc;
    wire irq = (mtime >= cmp_m);

    typedef struct packed { logic [31:0] a; logic [31:0] d; logic [63:0] c; } wr_t;
    wr_t wlog[$];

    always_comb begin
        rdata = 32'hDEAD_BEEF;
        if (addr == BASE)               rdata = mtime[31:0];
        else if (addr == BASE + 32'h4)  rdata = bad ? (h_base + hreads) : mtime[63:32];
        else if (addr == BASE + 32'h8)  rdata = cmp_m[31:0];
        else if (addr == BASE + 32'hC)  rdata = cmp_m[63:32];
    end

    always @(posedge clk) begin
        cyc <= cyc + 64'd1;
        if (rstrb && addr == BASE + 32'h4) hreads <= hreads + 32'd1;
        if (wr == 4'hF) begin
            wlog.push_back('{a: addr, d: wdata, c: cyc});
            if (addr == BASE + 32'h8)      cmp_m[31:0]  <= wdata;
            else if (addr == BASE + 32'hC) cmp_m[63:32] <= wdata;
        end
    end

    int proto_err = 0;
    int irq_cnt = 0;
    always @(negedge clk) begin
        if ((rstrb && wr != 4'h0) || (wr != 4'h0 && wr != 4'hF)) proto_err <= proto_err + 1;
        if (irq) irq_cnt <= irq_cnt + 1;
    end

    int vec = 0;
    int bad_n = 0;
    logic [63:0] exp_cmp = '1;
    logic [63:0] sh_model = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hi-lo-hi read of a timer whose mtime advances by one per cycle from m0 (cycle 0).
    task automatic model_read(input logic [63:0] m0, input bit is_cmp, input logic [31:0] h0,
                              output logic [63:0] val, output bit err, output int done);
        logic [31:0] ha, hb, lo;
        logic [63:0] t;
        err = 1'b1; val = 64'd0; done = 0;
        for (int a = 0; a < MAXR; a++) begin
            int s;
            s = 1 + 3 * a;
            if (is_cmp) begin
                ha = exp_cmp[63:32]; hb = ha; lo = exp_cmp[31:0];
            end else begin
                t  = m0 + 64'(s);     ha = t[63:32];
                t  = m0 + 64'(s + 1); lo = t[31:0];
                t  = m0 + 64'(s + 2); hb = t[63:32];
                if (bad) begin
                    ha = h0 + 32'(2 * a);
                    hb = h0 + 32'(2 * a + 1);
                end
            end
            done = s + 2;
            val = {hb, lo};
            if (ha == hb) begin
                err = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [63:0] data,
                           input logic [63:0] preset);
        logic [63:0] rval, wv, exp_data, c0;
        bit rerr, exp_err, got;
        int done, exp_lat, nw, k, wfirst;
        mt_base = preset - cyc;
        c0 = cyc;
        rval = 64'd0; rerr = 1'b0; done = 0;
        if (op != 2'b10) model_read(preset, op == 2'b01, h_base + hreads, rval, rerr, done);
        nw = 0; wfirst = 0; wv = 64'd0;
        if (op == 2'b10) begin
            wv = data; nw = 3; wfirst = 1; exp_lat = 4; exp_data = data; exp_err = 1'b0;
        end else if (op == 2'b11 && !rerr) begin
            wv = rval + data; nw = 3; wfirst = done + 1; exp_lat = done + 4;
            exp_data = wv; exp_err = 1'b0;
        end else begin
            exp_lat = done + 1; exp_data = rval; exp_err = rerr;
        end
        wlog.delete();
        check({tag, "/ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_op = op; req_data = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_data = {$urandom, $urandom};
        k = 1; got = 1'b0;
        while (k <= 60 && !got) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "/latency"}, 64'(k), 64'(exp_lat));
        check({tag, "/data"}, rsp_data, exp_data);
        check({tag, "/err"}, {63'd0, rsp_err}, {63'd0, exp_err});
        check({tag, "/nwrites"}, 64'(wlog.size()), 64'(nw));
        for (int i = 0; i < nw && i < wlog.size(); i++) begin
            logic [31:0] ea, ed;
            ea = (i == 1) ? BASE + 32'h8 : BASE + 32'hC;
            ed = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? wv[31:0] : wv[63:32];
            check({tag, "/waddr"}, {32'd0, wlog[i].a}, {32'd0, ea});
            check({tag, "/wdata"}, {32'd0, wlog[i].d}, {32'd0, ed});
            check({tag, "/wcycle"}, wlog[i].c - c0, 64'(wfirst + i));
        end
        if (nw == 3) begin
            exp_cmp = wv;
            sh_model = wv;
        end
        @(negedge clk);
        check({tag, "/pulse"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "/held"}, rsp_data, exp_data);
        $display("cmd %s op=%0d data=%h preset=%h -> rsp=%h err=%0d lat=%0d", tag, op, data,
                 preset, rsp_data, rsp_err, k);
    endtask

    initial begin
        int k, irq0, seen;
        logic [63:0] pre, dat;
        logic [1:0] op;

        repeat (2) @(negedge clk);
        check("rst/ready", {63'd0, req_ready}, 64'd0);
        check("rst/rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst/rsp_data", rsp_data, 64'd0);
        check("rst/rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst/addr", {32'd0, addr}, {32'd0, BASE});
        check("rst/wdata", {32'd0, wdata}, 64'd0);
        check("rst/wr", {60'd0, wr}, 64'd0);
        check("rst/rstrb", {63'd0, rstrb}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/ready_after", {63'd0, req_ready}, 64'd1);

        run_cmd("rd_stable", 2'b00, 64'd0, 64'h0000_0001_0000_0010);
        check("rd_stable/spec", rsp_data, 64'h0000_0001_0000_0012);
        run_cmd("rd_rollover", 2'b00, 64'd0, 64'h0000_0000_FFFF_FFFE);
        check("rd_rollover/spec", rsp_data, 64'h0000_0001_0000_0003);

        bad = 1'b1; h_base = 32'h0000_0100;
        run_cmd("arm_retry_fail", 2'b11, 64'd5, 64'h0000_0003_0000_0000);
        check("arm_retry_fail/err", {63'd0, rsp_err}, 64'd1);
        run_cmd("rd_retry_fail", 2'b00, 64'd0, 64'h0000_0003_0000_0000);
        bad = 1'b0;

        irq0 = irq_cnt;
        run_cmd("wr", 2'b10, 64'h0000_0002_0000_0100, 64'h0000_0001_0000_0000);
        check("wr/no_irq", 64'(irq_cnt - irq0), 64'd0);

        run_cmd("arm50", 2'b11, 64'd50, 64'd998);
        check("arm50/spec", rsp_data, 64'd1050);
        k = 0;
        while (mtime != 64'd1049 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("arm50/irq_before", {63'd0, irq}, 64'd0);
        @(negedge clk);
        check("arm50/irq_at", {63'd0, irq}, 64'd1);

        // reset in the middle of a write: only the all-ones hi write lands
        wlog.delete();
        req_valid = 1'b1; req_op = 2'b10; req_data = 64'h0000_0005_0000_0777;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid/wr", {60'd0, wr}, 64'd0);
        check("rstmid/rstrb", {63'd0, rstrb}, 64'd0);
        check("rstmid/addr", {32'd0, addr}, {32'd0, BASE});
        check("rstmid/wdata", {32'd0, wdata}, 64'd0);
        check("rstmid/ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rstmid/no_rsp", 64'(seen), 64'd0);
        check("rstmid/partial", 64'(wlog.size()), 64'd1);
        exp_cmp = {32'hFFFF_FFFF, exp_cmp[31:0]};
        sh_model = 64'd0;
        run_cmd("rstmid/after", 2'b01, 64'd0, 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            pre = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pre[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            dat = {$urandom, $urandom};
            run_cmd($sformatf("rnd%0d", i), op, dat, pre);
        end

`ifdef TIMER_CLIENT_PERIODIC_EN
        periodic_on = 1'b1; period = 32'd100;
        wlog.delete();
        irq_p = 1'b1;
        req_valid = 1'b1; req_op = 2'b01; req_data = 64'd0;
        #1;
        check("per/ready_blocked", {63'd0, req_ready}, 64'd0);
        pre = cyc;
        @(posedge clk);
        @(negedge clk);
        irq_p = 1'b0;
        k = 1;
        while (k <= 40 && !rsp_valid) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        check("per/latency", 64'(k), 64'd8);
        check("per/cmp_sh", rsp_data, sh_model + 64'd100);
        check("per/nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            check("per/wlo", {32'd0, wlog[1].d}, {32'd0, 32'(sh_model + 64'd100)});
            check("per/wcycle", wlog[0].c - pre, 64'd1);
        end
        $display("cmd periodic period=100 -> rsp=%h lat=%0d", rsp_data, k);
        periodic_on = 1'b0;
        @(negedge clk);
`endif

        check("bus/protocol", 64'(proto_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad_n);
        $finish;
    end
endmodule
